// File: rtl/unidad_de_busqueda_pkg.sv
// Shared definitions for the instruction fetch/sequencer.
// Contents: FSM state encodings, instruction field positions, the jump
// opcode constant and default widths used by unidad_de_busqueda and
// contador_de_programa.
package unidad_de_busqueda_pkg;

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    BUSQUEDA   = 2'b01,
    DECODIFICA = 2'b10,
    EJECUTA    = 2'b11
  } estado_t;

  localparam int OPCODE_MSB = 8;
  localparam int OPCODE_LSB = 6;
  localparam int OPER_MSB   = 5;

  localparam logic [2:0] SALTO = 3'b111;

  localparam int ANCHO_PC_DEF   = 6;
  localparam int ANCHO_INST_DEF = 9;
  localparam int DIR_RESET_DEF  = 0;
  localparam int MAX_ESPERA_DEF = 15;

endpackage

// File: rtl/unidad_de_busqueda_contador_de_programa.sv
// Program counter register.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset, loads DIR_RESET
//   cargar      - load destino (jump); wins over incrementar
//   incrementar - advance PC by one, wrapping at 2^ANCHO_PC
//   destino     - jump target
//   pc          - current program counter
module contador_de_programa
  import unidad_de_busqueda_pkg::*;
#(
  parameter int ANCHO_PC  = ANCHO_PC_DEF,
  parameter int DIR_RESET = DIR_RESET_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cargar,
  input  logic                incrementar,
  input  logic [ANCHO_PC-1:0] destino,
  output logic [ANCHO_PC-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ANCHO_PC'(DIR_RESET);
    end else if (cargar) begin
      pc <= destino;
    end else if (incrementar) begin
      // Natural modulo-2^ANCHO_PC wrap of the adder.
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/unidad_de_busqueda.sv
// Instruction fetch/sequencer feeding the control unit.
// Reads instruction words over a read/valid handshake, presents
// opcode/operands for one decode cycle, waits for execution to finish and
// then either jumps (PC <= operand field) or increments the PC.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ESPERA     | idle; fetch starts when i_Hab=1 and no sticky error
// BUSQUEDA   | memory read outstanding at PC; times out after MAX_ESPERA
// DECODIFICA | new instruction presented, o_Inst_valida pulses
// EJECUTA    | waiting for i_Ejecucion_lista, then jump or PC+1
//
// Ports:
//   i_Timming, i_Rst           - clock / synchronous active-high reset
//   i_Hab                      - run enable (level)
//   o_Mem_dir, o_Mem_lee       - program memory address / read request
//   i_Mem_dato, i_Mem_valido   - program memory data / data valid
//   o_Operation_code, o_Operandos, o_Inst_valida - to control unit
//   i_Senal_de_salto, i_Ejecucion_lista          - from control unit
//   o_PC, o_Estado, o_Error    - PC, state (debug), sticky timeout flag
module unidad_de_busqueda
  import unidad_de_busqueda_pkg::*;
#(
  parameter int ANCHO_PC   = ANCHO_PC_DEF,
  parameter int ANCHO_INST = ANCHO_INST_DEF,
  parameter int DIR_RESET  = DIR_RESET_DEF,
  parameter int MAX_ESPERA = MAX_ESPERA_DEF
) (
  input  logic                  i_Timming,
  input  logic                  i_Rst,
  input  logic                  i_Hab,
  output logic [ANCHO_PC-1:0]   o_Mem_dir,
  output logic                  o_Mem_lee,
  input  logic [ANCHO_INST-1:0] i_Mem_dato,
  input  logic                  i_Mem_valido,
  output logic [2:0]            o_Operation_code,
  output logic [5:0]            o_Operandos,
  output logic                  o_Inst_valida,
  input  logic                  i_Senal_de_salto,
  input  logic                  i_Ejecucion_lista,
  output logic [ANCHO_PC-1:0]   o_PC,
  output logic [1:0]            o_Estado,
  output logic                  o_Error
);

  localparam int ANCHO_CNT = $clog2(MAX_ESPERA + 1);
  // Counter holds the number of empty cycles already spent; the cycle that
  // sees LIMITE without valid is the MAX_ESPERA-th one.
  localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(MAX_ESPERA - 1);

  estado_t               estado;
  logic [ANCHO_INST-1:0] ir;
  logic [ANCHO_CNT-1:0]  cnt_espera;
  logic                  error;
  logic                  mem_lee;
  logic                  inst_valida;
  logic [ANCHO_PC-1:0]   pc;

  logic fin_ejecucion;
  logic cargar_pc;
  logic incrementar_pc;

  // Salto is only meaningful in the cycle execution completes.
  assign fin_ejecucion  = (estado == EJECUTA) && i_Ejecucion_lista;
  assign cargar_pc      = fin_ejecucion && i_Senal_de_salto;
  assign incrementar_pc = fin_ejecucion && !i_Senal_de_salto;

  contador_de_programa #(
    .ANCHO_PC  (ANCHO_PC),
    .DIR_RESET (DIR_RESET)
  ) u_pc (
    .clk         (i_Timming),
    .rst         (i_Rst),
    .cargar      (cargar_pc),
    .incrementar (incrementar_pc),
    .destino     (ANCHO_PC'(ir[OPER_MSB:0])),
    .pc          (pc)
  );

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      estado      <= ESPERA;
      ir          <= '0;
      cnt_espera  <= '0;
      error       <= 1'b0;
      mem_lee     <= 1'b0;
      inst_valida <= 1'b0;
    end else begin
      inst_valida <= 1'b0;
      case (estado)
        ESPERA: begin
          if (i_Hab && !error) begin
            estado     <= BUSQUEDA;
            mem_lee    <= 1'b1;
            cnt_espera <= '0;
          end
        end
        BUSQUEDA: begin
          if (i_Mem_valido) begin
            ir          <= i_Mem_dato;
            cnt_espera  <= '0;
            mem_lee     <= 1'b0;
            inst_valida <= 1'b1;
            estado      <= DECODIFICA;
          end else if (cnt_espera == LIMITE) begin
            error      <= 1'b1;
            cnt_espera <= '0;
            mem_lee    <= 1'b0;
            estado     <= ESPERA;
          end else begin
            cnt_espera <= cnt_espera + 1'b1;
          end
        end
        DECODIFICA: begin
          estado <= EJECUTA;
        end
        EJECUTA: begin
          if (i_Ejecucion_lista) begin
            if (i_Hab) begin
              estado  <= BUSQUEDA;
              mem_lee <= 1'b1;
            end else begin
              estado <= ESPERA;
            end
          end
        end
        default: begin
          estado  <= ESPERA;
          mem_lee <= 1'b0;
        end
      endcase
    end
  end

  assign o_Mem_dir        = pc;
  assign o_PC             = pc;
  assign o_Mem_lee        = mem_lee;
  assign o_Operation_code = ir[OPCODE_MSB:OPCODE_LSB];
  assign o_Operandos      = ir[OPER_MSB:0];
  assign o_Inst_valida    = inst_valida;
  assign o_Estado         = estado;
  assign o_Error          = error;

endmodule

// File: tb/tb_unidad_de_busqueda.sv
// Directed bench for unidad_de_busqueda: fetch, decode pulse, jump and
// increment, PC wrap, self-loop jump, i_Hab drop mid-instruction, reset
// during execution and memory timeout with sticky error.
module tb_unidad_de_busqueda;

  logic       clk;
  logic       rst;
  logic       hab;
  logic [5:0] mem_dir;
  logic       mem_lee;
  logic [8:0] mem_dato;
  logic       mem_valido;
  logic [2:0] opcode;
  logic [5:0] operandos;
  logic       inst_valida;
  logic       salto;
  logic       lista;
  logic [5:0] pc;
  logic [1:0] estado;
  logic       error;

  int vectors = 0;
  int miscompares = 0;

  unidad_de_busqueda dut (
    .i_Timming         (clk),
    .i_Rst             (rst),
    .i_Hab             (hab),
    .o_Mem_dir         (mem_dir),
    .o_Mem_lee         (mem_lee),
    .i_Mem_dato        (mem_dato),
    .i_Mem_valido      (mem_valido),
    .o_Operation_code  (opcode),
    .o_Operandos       (operandos),
    .o_Inst_valida     (inst_valida),
    .i_Senal_de_salto  (salto),
    .i_Ejecucion_lista (lista),
    .o_PC              (pc),
    .o_Estado          (estado),
    .o_Error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Called while in BUSQUEDA: holds valid low for 'esperas' cycles, then
  // returns 'dato' and walks through DECODIFICA into EJECUTA.
  task automatic fetch(input logic [8:0] dato, input int esperas,
                       input logic [5:0] exp_dir);
    chk("busq_estado", 32'(estado), 1);
    chk("busq_lee", 32'(mem_lee), 1);
    chk("busq_dir", 32'(mem_dir), 32'(exp_dir));
    for (int i = 0; i < esperas; i++) step();
    mem_valido = 1'b1;
    mem_dato   = dato;
    step();
    mem_valido = 1'b0;
    mem_dato   = 9'h000;
    chk("dec_estado", 32'(estado), 2);
    chk("dec_pulso", 32'(inst_valida), 1);
    chk("dec_opcode", 32'(opcode), 32'(dato[8:6]));
    chk("dec_oper", 32'(operandos), 32'(dato[5:0]));
    chk("dec_lee", 32'(mem_lee), 0);
    step();
    chk("ejec_estado", 32'(estado), 3);
    chk("ejec_pulso", 32'(inst_valida), 0);
  endtask

  // Called in EJECUTA: 'fantasmas' cycles of salto=1 with lista=0 must not
  // move the PC, then lista=1 with the given salto.
  task automatic finish(input int fantasmas, input logic [5:0] pc_prev,
                        input logic s, input logic [5:0] exp_pc,
                        input logic [1:0] exp_estado);
    for (int i = 0; i < fantasmas; i++) begin
      salto = 1'b1;
      lista = 1'b0;
      step();
      chk("fantasma_pc", 32'(pc), 32'(pc_prev));
      chk("fantasma_estado", 32'(estado), 3);
    end
    salto = s;
    lista = 1'b1;
    step();
    lista = 1'b0;
    salto = 1'b0;
    chk("fin_pc", 32'(pc), 32'(exp_pc));
    chk("fin_dir", 32'(mem_dir), 32'(exp_pc));
    chk("fin_estado", 32'(estado), 32'(exp_estado));
    chk("fin_lee", 32'(mem_lee), (exp_estado == 2'b01) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1; hab = 1'b0; mem_dato = 9'h000; mem_valido = 1'b0;
    salto = 1'b0; lista = 1'b0;
    step();
    step();
    chk("rst_estado", 32'(estado), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_dir", 32'(mem_dir), 0);
    chk("rst_lee", 32'(mem_lee), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_oper", 32'(operandos), 0);
    chk("rst_pulso", 32'(inst_valida), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;
    step();
    chk("idle_estado", 32'(estado), 0);

    // First instruction: plain, memory answers one cycle late.
    hab = 1'b1;
    step();
    fetch(9'b000111101, 1, 6'd0);
    finish(0, 6'd0, 1'b0, 6'd1, 2'b01);
    chk("opcode_estable", 32'(opcode), 0);
    chk("oper_estable", 32'(operandos), 32'h3d);

    // Jump to 13.
    fetch(9'b111001101, 1, 6'd1);
    finish(0, 6'd1, 1'b1, 6'd13, 2'b01);
    // Same word without jump.
    fetch(9'b111001101, 1, 6'd13);
    finish(0, 6'd13, 1'b0, 6'd14, 2'b01);
    // Salto asserted while lista low is ignored.
    fetch(9'b111001101, 0, 6'd14);
    finish(2, 6'd14, 1'b0, 6'd15, 2'b01);

    // Jump to 63, then a non-jump wraps to 0.
    fetch(9'b111111111, 1, 6'd15);
    finish(0, 6'd15, 1'b1, 6'd63, 2'b01);
    fetch(9'b010000011, 1, 6'd63);
    finish(0, 6'd63, 1'b0, 6'd0, 2'b01);

    // Self-loop jump with zero-wait memory.
    fetch(9'b111000000, 0, 6'd0);
    finish(0, 6'd0, 1'b1, 6'd0, 2'b01);

    // Enable dropped during BUSQUEDA: completes, then parks.
    hab = 1'b0;
    fetch(9'b001000100, 1, 6'd0);
    finish(0, 6'd0, 1'b0, 6'd1, 2'b00);
    step();
    chk("parked_estado", 32'(estado), 0);
    chk("parked_lee", 32'(mem_lee), 0);

    // Reset during EJECUTA with lista/salto pending.
    hab = 1'b1;
    step();
    fetch(9'b111000101, 1, 6'd1);
    salto = 1'b1;
    lista = 1'b1;
    rst   = 1'b1;
    step();
    rst = 1'b0; lista = 1'b0; salto = 1'b0; hab = 1'b0;
    chk("rstx_estado", 32'(estado), 0);
    chk("rstx_pc", 32'(pc), 0);
    chk("rstx_opcode", 32'(opcode), 0);
    chk("rstx_oper", 32'(operandos), 0);
    chk("rstx_lee", 32'(mem_lee), 0);
    chk("rstx_pulso", 32'(inst_valida), 0);

    // Timeout: memory never answers.
    hab = 1'b1;
    step();
    chk("to_inicio", 32'(estado), 1);
    for (int i = 1; i <= 14; i++) step();
    chk("to_14_estado", 32'(estado), 1);
    chk("to_14_error", 32'(error), 0);
    step();
    chk("to_15_estado", 32'(estado), 0);
    chk("to_15_error", 32'(error), 1);
    chk("to_15_lee", 32'(mem_lee), 0);
    chk("to_15_pc", 32'(pc), 0);
    for (int i = 0; i < 3; i++) step();
    chk("to_bloqueo_estado", 32'(estado), 0);
    chk("to_bloqueo_error", 32'(error), 1);
    hab = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_rst_error", 32'(error), 0);
    chk("to_rst_pc", 32'(pc), 0);
    chk("to_rst_estado", 32'(estado), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
